// File: rtl/arc_debug_scanner.sv
// Host-side debug-port scanner: walks every register index, then every pipeline
// stage (pc and ir), then the custom word, and streams each capture over valid/ready.
module arc_debug_scanner #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_REGS      = 32,
  parameter int NUM_STAGES    = 5
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] chip_debug_in,
  input  logic [31:0] chip_debug_out0,
  input  logic [31:0] chip_debug_out1,
  input  logic [31:0] chip_debug_out2,
  input  logic [31:0] chip_debug_out3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_tag
);

  // Word 42 (the custom word) is the last one of a scan.
  localparam logic [5:0] FIRST_STG = 6'(NUM_REGS);
  localparam logic [5:0] LAST_IDX  = 6'(NUM_REGS + 2 * NUM_STAGES);
  localparam logic [3:0] CNT_LOAD  = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST_STG  = 3'(NUM_STAGES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, DONE} state_e;

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] data;
  } word_t;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [2:0]  stage_q, stage_d;
  logic        fld_q, fld_d;
  logic [3:0]  cnt_q, cnt_d;
  word_t       word_q, word_d;

  logic        is_reg, is_custom, hs, last;
  logic [31:0] sel;
  word_t       cap;

  assign is_reg    = (idx_q < FIRST_STG);
  assign is_custom = (idx_q == LAST_IDX);
  assign hs        = (state_q == EMIT) && out_ready;
  assign last      = is_custom;

  // Selection and capture for the current word index.
  always_comb begin
    sel      = 32'd0;
    cap.tag  = 8'hFF;
    cap.data = chip_debug_out3;
    if (is_reg) begin
      sel      = {24'd0, 3'd0, idx_q[4:0]};
      cap.tag  = {2'b00, idx_q};
      cap.data = chip_debug_out0;
    end else if (!is_custom) begin
      sel      = {24'd0, stage_q, 5'd0};
      cap.tag  = {4'b1000, stage_q, fld_q};
      cap.data = fld_q ? chip_debug_out2 : chip_debug_out1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (cnt_q == 4'd0) state_d = EMIT;
      EMIT:    if (hs) state_d = last ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == SETTLE) || (state_q == EMIT);
    done          = (state_q == DONE);
    out_valid     = (state_q == EMIT);
    chip_debug_in = busy ? sel : 32'd0;
  end

  // Word/stage/field counters, settle timer and capture register.
  always_comb begin
    idx_d   = idx_q;
    stage_d = stage_q;
    fld_d   = fld_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: if (start) begin
        idx_d   = 6'd0;
        stage_d = 3'd0;
        fld_d   = 1'b0;
        cnt_d   = CNT_LOAD;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) word_d = cap;
        else               cnt_d  = cnt_q - 4'd1;
      end
      EMIT: if (hs && !last) begin
        idx_d = idx_q + 6'd1;
        cnt_d = CNT_LOAD;
        // Stage/field advance only between two stage words; stays at the last stage.
        if (!is_reg && (idx_q != LAST_IDX - 6'd1)) begin
          fld_d = ~fld_q;
          if (fld_q && stage_q != LAST_STG) stage_d = stage_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      idx_q   <= 6'd0;
      stage_q <= 3'd0;
      fld_q   <= 1'b0;
      cnt_q   <= 4'd0;
      word_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      stage_q <= stage_d;
      fld_q   <= fld_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  assign out_data = word_q.data;
  assign out_tag  = word_q.tag;

endmodule

// File: doc/arc_debug_scanner.md
Name: arc_debug_scanner

Overview:
- Host-side master of the CPU chip-debug port.
- On a start pulse it sweeps chip_debug_in over all 32 register indices, then all 5 pipeline stages.
- For each selection it samples the CPU's combinational debug outputs after a settle delay.
- It streams every captured word, with an identifying tag, over a valid/ready interface to a downstream display/UART sink.

Parameters:
- SETTLE_CYCLES, 2, cycles chip_debug_in is held before sampling (legal range 1..15).
- NUM_REGS, 32, register words emitted (fixed by 5-bit index).
- NUM_STAGES, 5, pipeline stages emitted (IF, ID, EX, MEM, WB).

Ports:
- clk  in  1  system clock
- aresetn  in  1  reset, asynchronous, active-low
- start  in  1  begin a scan (single-cycle pulse; ignored while busy)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last word is transferred
- chip_debug_in  out  32  selection to CPU: {24'b0, stage[2:0], reg[4:0]}
- chip_debug_out0  in  32  CPU register value for reg[4:0]
- chip_debug_out1  in  32  CPU pc for stage[2:0]
- chip_debug_out2  in  32  CPU ir for stage[2:0]
- chip_debug_out3  in  32  CPU custom debug word
- out_valid  out  1  out_data/out_tag valid
- out_ready  in  1  sink accepts word
- out_data  out  32  captured word
- out_tag  out  8  word id (see below)

Behaviour:
- Reset is asynchronous, active-low. While aresetn=0: state IDLE; busy, done, out_valid = 0; out_data, out_tag, chip_debug_in = 0; all counters = 0. Assertion mid-scan aborts immediately with no partial done.
- Word sequence, 43 words per scan:
  - Words 0..31: reg i; chip_debug_in = i; sample out0; tag = 8'h00+i.
  - Words 32..41: stage s (0..4), field f (0=pc, 1=ir); chip_debug_in = s<<5; sample out1 (f=0) or out2 (f=1); tag = 8'h80 | (s<<1) | f.
  - Word 42: custom word; chip_debug_in = 0; sample out3; tag = 8'hFF.
- FSM states: IDLE, SETTLE, EMIT, DONE.
  - IDLE: chip_debug_in = 0. start=1 at a clock edge → SETTLE with word index 0, settle counter = SETTLE_CYCLES-1, busy=1.
  - SETTLE: chip_debug_in drives the current word's selection. Counter decrements each cycle. At counter==0 the selected input is registered into out_data, out_tag is loaded, and the FSM moves → EMIT.
  - EMIT: out_valid=1. out_data, out_tag and chip_debug_in are held stable until out_valid&&out_ready. out_valid must not drop without a handshake.
    - On handshake with index<42: index++, → SETTLE (counter reloaded).
    - On handshake with index==42: → DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then → IDLE.
- Timing with out_ready tied high: start sampled at edge k gives first out_valid from edge k+SETTLE_CYCLES. Each word occupies SETTLE_CYCLES+1 cycles. done is high in the cycle after the last handshake.
- start is ignored in SETTLE, EMIT and DONE. A start in the same cycle as done is ignored.
- out_ready may be held low indefinitely. The scanner stalls in EMIT with no loss or duplication of words.
- Captured values reflect the CPU state SETTLE_CYCLES cycles after selection. The scanner does not stall the CPU; a stepping CPU may change values between words.
- Word index: 6-bit counter. Stage index: 3-bit, never exceeds 4. No wrap beyond word 42.

Test Plan:
- Reset values: hold aresetn=0 with start=1 → busy=0, out_valid=0, chip_debug_in=0. Release aresetn, pulse start → first out_valid 2 cycles after the start edge (SETTLE_CYCLES=2).
- Full scan, out_ready=1, CPU model returns out0=0x1000+idx, out1=0x2000+stage, out2=0x3000+stage, out3=0xDEADBEEF:
  - 43 words in order.
  - Word 5 = {tag 8'h05, data 0x1005}; word 39 = {tag 8'h87, data 0x3003}; word 42 = {tag 8'hFF, data 0xDEADBEEF}.
  - done exactly 129 cycles after the start edge.
- Backpressure: out_ready low for 10 cycles on word 3 → out_data=0x1003, tag=8'h03 and chip_debug_in=3 stable throughout; no word skipped or repeated; random ready on the remaining words gives the same 43-word sequence.
- Selection timing: the model changes out0 one cycle after chip_debug_in changes → captured value is still correct for SETTLE_CYCLES=2, and checks chip_debug_in=32'h80 during stage-4 words.
- start while busy: pulse start at word 10 and on the done cycle → no restart; exactly 43 words and one done pulse.
- Abort: drop aresetn during word 20 EMIT → out_valid and busy fall asynchronously; no done. A new start produces a full 43-word scan from tag 8'h00.
